// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - command codes shared by the universal shift register
package usr_pkg;
    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;
endpackage

// File: rtl/usr_step.sv
// rtl/usr_step.sv - one combinational bit step of a shift or rotate command
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             sin,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] q_next,
    output logic             sout_next
);
    always_comb begin
        q_next    = q;
        sout_next = 1'b0;
        case (mode)
            MODE_SHL: begin
                q_next    = {q[WIDTH-2:0], sin};
                sout_next = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next    = {sin, q[WIDTH-1:1]};
                sout_next = q[0];
            end
            MODE_ROL: begin
                q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
                sout_next = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next    = {q[0], q[WIDTH-1:1]};
                sout_next = q[0];
            end
            MODE_ASR: begin
                q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
                sout_next = q[0];
            end
            default: begin
                q_next    = q;
                sout_next = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - WIDTH-bit register with load/clear and
// multi-cycle shift/rotate commands under a busy/done handshake
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    logic [2:0]       mode_r;
    logic [AMT_W-1:0] remaining;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] q_next;
    logic             sout_next;

    // The first step happens on the accept edge, before mode is latched.
    assign step_mode = busy ? mode_r : mode;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q        (q),
        .sin      (sin),
        .mode     (step_mode),
        .q_next   (q_next),
        .sout_next(sout_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            sout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            mode_r    <= MODE_HOLD;
        end else begin
            done <= 1'b0;
            if (busy) begin
                q         <= q_next;
                sout      <= sout_next;
                remaining <= remaining - 1'b1;
                if (remaining == AMT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (enable) begin
                case (mode)
                    MODE_HOLD: done <= 1'b1;
                    MODE_LOAD: begin
                        q    <= d;
                        done <= 1'b1;
                    end
                    MODE_CLEAR: begin
                        q    <= '0;
                        sout <= 1'b0;
                        done <= 1'b1;
                    end
                    default: begin
                        mode_r <= mode;
                        if (amt == '0) begin
                            done <= 1'b1;
                        end else begin
                            q         <= q_next;
                            sout      <= sout_next;
                            remaining <= amt - 1'b1;
                            busy      <= (amt != AMT_W'(1));
                            done      <= (amt == AMT_W'(1));
                        end
                    end
                endcase
            end
        end
    end
endmodule
